// File: rtl/asin_calculator.sv
// asin_calculator
//   Table-driven arcsine. Software loads a 2**ADDR_BITS-entry table of
//   (sine key, angle) pairs. A request runs a fixed-length bitwise binary
//   search over the sine keys using the operand magnitude. It returns the
//   matching angle with the operand's sign applied. Operands above 1.0 in
//   magnitude, and NaNs, return a canonical NaN with the same timing.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   inp_valid      request strobe (ignored while busy)
//   inp_value      operand x, IEEE-style float, W bits
//   busy           search in progress; requests and table writes rejected
//   out_value      asin result, held until the next result
//   out_data_ready one-cycle result strobe
//   lut_wr_en      table write strobe
//   lut_wr_addr    table entry index
//   lut_wr_sine    sine key for the entry
//   lut_wr_angle   angle value for the entry
//   lut_wr_drop    one-cycle pulse: a write arrived while busy and was dropped

module asin_calculator #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int ADDR_BITS    = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inp_valid,
  input  logic [EXP_LEN+MANTISSA_LEN:0]     inp_value,
  output logic                              busy,
  output logic [EXP_LEN+MANTISSA_LEN:0]     out_value,
  output logic                              out_data_ready,
  input  logic                              lut_wr_en,
  input  logic [ADDR_BITS-1:0]              lut_wr_addr,
  input  logic [EXP_LEN+MANTISSA_LEN:0]     lut_wr_sine,
  input  logic [EXP_LEN+MANTISSA_LEN:0]     lut_wr_angle,
  output logic                              lut_wr_drop
);

  localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (ADDR_BITS > 1) ? $clog2(ADDR_BITS) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ADDR_BITS - 1);

  // Magnitude of +1.0: biased exponent 0111..1, zero mantissa.
  localparam logic [W-2:0] ONE_MAG =
    {1'b0, {(EXP_LEN-1){1'b1}}, {MANTISSA_LEN{1'b0}}};

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
  localparam logic [W-1:0] CANON_NAN =
    {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} stateType;

  stateType r_state;
  stateType w_nextState;

  logic [W-1:0]         r_sineLut  [DEPTH];
  logic [W-1:0]         r_angleLut [DEPTH];

  logic [ADDR_BITS-1:0] r_idx;
  logic [CNT_W-1:0]     r_bitCnt;
  logic                 r_sign;
  logic [W-2:0]         r_mag;
  logic [W-1:0]         r_outValue;
  logic                 r_outReady;
  logic                 r_wrDrop;

  logic                 w_accept;
  logic                 w_wrAccept;
  logic                 w_searchStep;
  logic                 w_lastStep;
  logic                 w_finish;

  logic [ADDR_BITS-1:0] w_candMask;
  logic [ADDR_BITS-1:0] w_cand;
  logic [W-1:0]         w_candSine;
  logic [W-1:0]         w_idxAngle;
  logic                 w_takeCand;
  logic                 w_isNan;
  logic                 w_special;

  // Table sign bits carry no meaning here. The search compares
  // magnitudes, and the result takes the operand's sign.
  logic [1:0]           w_unusedSignBits;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. SEARCH lasts one edge per address bit.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (inp_valid) w_nextState = SEARCH;
      SEARCH:  if (w_lastStep) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_wrAccept   = 1'b0;
    w_searchStep = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept   = inp_valid;
        w_wrAccept = lut_wr_en;
      end
      SEARCH: begin
        busy         = 1'b1;
        w_searchStep = 1'b1;
      end
      DONE: begin
        busy     = 1'b1;
        w_finish = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign w_lastStep = (r_bitCnt == '0);

  // Probe one bit per step, from the MSB down. The table is nondecreasing,
  // so idx ends as the last entry whose key does not exceed the magnitude.
  assign w_candMask = ADDR_BITS'(1) << r_bitCnt;
  assign w_cand     = r_idx | w_candMask;
  assign w_candSine = r_sineLut[w_cand];
  assign w_idxAngle = r_angleLut[r_idx];
  assign w_takeCand = (w_candSine[W-2:0] <= r_mag);

  assign w_isNan   = (r_mag[W-2:MANTISSA_LEN] == '1) &&
                     (r_mag[MANTISSA_LEN-1:0] != '0);
  assign w_special = w_isNan || (r_mag > ONE_MAG);

  assign w_unusedSignBits = {w_candSine[W-1], w_idxAngle[W-1]};

  // Table storage. Writes land only while idle. A write on the accept edge
  // therefore lands before the first search probe reads the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sineLut[i]  <= '0;
        r_angleLut[i] <= '0;
      end
    end else if (w_wrAccept) begin
      r_sineLut[lut_wr_addr]  <= lut_wr_sine;
      r_angleLut[lut_wr_addr] <= lut_wr_angle;
    end
  end

  // Datapath. Latches the operand, steps the search, and registers the
  // result and the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_bitCnt   <= LAST_BIT;
      r_sign     <= 1'b0;
      r_mag      <= '0;
      r_outValue <= '0;
      r_outReady <= 1'b0;
      r_wrDrop   <= 1'b0;
    end else begin
      r_outReady <= w_finish;
      r_wrDrop   <= lut_wr_en && busy;
      if (w_accept) begin
        r_sign   <= inp_value[W-1];
        r_mag    <= inp_value[W-2:0];
        r_idx    <= '0;
        r_bitCnt <= LAST_BIT;
      end else if (w_searchStep) begin
        if (w_takeCand) begin
          r_idx <= w_cand;
        end
        if (!w_lastStep) begin
          r_bitCnt <= r_bitCnt - CNT_W'(1);
        end
      end
      if (w_finish) begin
        r_outValue <= w_special ? CANON_NAN : {r_sign, w_idxAngle[W-2:0]};
      end
    end
  end

  assign out_value      = r_outValue;
  assign out_data_ready = r_outReady;
  assign lut_wr_drop    = r_wrDrop;

endmodule

// File: tb/tb_asin_calculator.sv
// tb_asin_calculator
//   Self-checking bench for asin_calculator (default parameters).
//   A behavioural model tracks the expected busy, result, strobe and drop
//   outputs. It uses plain table scans and an edge countdown. A compare
//   process checks the DUT against it on every falling edge. Directed cases
//   pin the model with hand-computed literal results and latencies.

module tb_asin_calculator;

  localparam int W   = 32;
  localparam int LAT = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inp_valid = 1'b0;
  logic [31:0] inp_value = '0;
  logic        busy;
  logic [31:0] out_value;
  logic        out_data_ready;
  logic        lut_wr_en = 1'b0;
  logic [5:0]  lut_wr_addr = '0;
  logic [31:0] lut_wr_sine = '0;
  logic [31:0] lut_wr_angle = '0;
  logic        lut_wr_drop;

  int checks = 0;
  int fails  = 0;

  asin_calculator dut (
    .clk            (clk),
    .rst            (rst),
    .inp_valid      (inp_valid),
    .inp_value      (inp_value),
    .busy           (busy),
    .out_value      (out_value),
    .out_data_ready (out_data_ready),
    .lut_wr_en      (lut_wr_en),
    .lut_wr_addr    (lut_wr_addr),
    .lut_wr_sine    (lut_wr_sine),
    .lut_wr_angle   (lut_wr_angle),
    .lut_wr_drop    (lut_wr_drop)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] mSine  [64];
  logic [31:0] mAngle [64];
  int          mRemain   = 0;
  logic [31:0] mPending  = '0;
  logic [31:0] expValue  = '0;
  logic        expReady  = 1'b0;
  logic        expDrop   = 1'b0;

  initial begin
    for (int k = 0; k < 64; k++) begin
      mSine[k]  = '0;
      mAngle[k] = '0;
    end
  end

  // asin by table: the last entry whose key magnitude does not exceed |x|.
  function automatic logic [31:0] modelAsin(input logic [31:0] x);
    logic [30:0] mag;
    int best;
    mag = x[30:0];
    if ((mag[30:23] == 8'hFF && mag[22:0] != 0) || mag > 31'h3F800000)
      return 32'h7FC00000;
    best = 0;
    for (int k = 0; k < 64; k++)
      if (mSine[k][30:0] <= mag) best = k;
    return {x[31], mAngle[best][30:0]};
  endfunction

  // Model timeline. An accepted request keeps the block busy for LAT edges.
  // The result strobe follows the last of those edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) begin
        mSine[k]  = '0;
        mAngle[k] = '0;
      end
      mRemain  = 0;
      expValue = '0;
      expReady = 1'b0;
      expDrop  = 1'b0;
    end else begin
      expDrop  = lut_wr_en && (mRemain != 0);
      expReady = (mRemain == 1);
      if (mRemain == 1) expValue = mPending;
      if (mRemain != 0) begin
        mRemain--;
      end else begin
        if (lut_wr_en) begin
          mSine[lut_wr_addr]  = lut_wr_sine;
          mAngle[lut_wr_addr] = lut_wr_angle;
        end
        if (inp_valid) begin
          mPending = modelAsin(inp_value);
          mRemain  = LAT;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    checkOutput("busy", 32'(busy), 32'(mRemain != 0));
    checkOutput("out_data_ready", 32'(out_data_ready), 32'(expReady));
    checkOutput("lut_wr_drop", 32'(lut_wr_drop), 32'(expDrop));
    checkOutput("out_value", out_value, expValue);
  end

  function automatic logic [31:0] kToFloat(input int k, input int scaleExp);
    int p;
    logic [31:0] m;
    if (k == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 6; i++) if (k[i]) p = i;
    m = 32'(k) << (23 - p);
    return {1'b0, 8'(127 + p + scaleExp), m[22:0]};
  endfunction

  function automatic logic [31:0] randX();
    logic [31:0] v;
    int kind;
    kind = $urandom_range(0, 5);
    case (kind)
      0, 1: v = {1'b0, 31'($urandom_range(0, 32'h3F800000))};
      2:    v = {1'b0, mSine[$urandom_range(0, 63)][30:0]};
      3:    v = {1'b0, 31'($urandom_range(32'h3F800001, 32'h7F7FFFFF))};
      4:    v = {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      default: v = 32'h3F800000;
    endcase
    v[31] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic writeEntry(input int k, input logic [31:0] s, input logic [31:0] a);
    @(negedge clk); #1;
    lut_wr_en    = 1'b1;
    lut_wr_addr  = 6'(k);
    lut_wr_sine  = s;
    lut_wr_angle = a;
    @(posedge clk); #1;
    lut_wr_en = 1'b0;
  endtask

  // Called just after the accept edge. Waits a bounded number of edges for
  // the result strobe and returns the edge count since accept.
  task automatic waitResult(input bit wrBusy, input bit noise,
                            output logic [31:0] res, output int lat, output bit dropSeen);
    lat = 0;
    res = '0;
    dropSeen = 0;
    if (wrBusy) begin
      lut_wr_en    = 1'b1;
      lut_wr_addr  = 6'd32;
      lut_wr_sine  = $urandom;
      lut_wr_angle = $urandom;
    end
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #1;
      lut_wr_en = 1'b0;
      if (noise) begin
        inp_valid = (n == 1);
        inp_value = $urandom;
      end
      if (lut_wr_drop) dropSeen = 1;
      if (out_data_ready) begin
        lat = n;
        res = out_value;
      end
    end
    if (lat == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL result timeout: no out_data_ready within 20 edges");
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input bit sameEdgeWr,
                               input logic [5:0] addr, input logic [31:0] s,
                               input logic [31:0] a, input bit wrBusy, input bit noise,
                               output logic [31:0] res, output int lat, output bit dropSeen);
    @(negedge clk); #1;
    inp_valid = 1'b1;
    inp_value = x;
    if (sameEdgeWr) begin
      lut_wr_en    = 1'b1;
      lut_wr_addr  = addr;
      lut_wr_sine  = s;
      lut_wr_angle = a;
    end
    @(posedge clk); #1;
    inp_valid = 1'b0;
    lut_wr_en = 1'b0;
    waitResult(wrBusy, noise, res, lat, dropSeen);
  endtask

  task automatic runDirected(input string name, input logic [31:0] x, input logic [31:0] expected);
    logic [31:0] res;
    int lat;
    bit drop;
    applyStimulus(x, 0, 6'd0, 32'h0, 32'h0, 0, 0, res, lat, drop);
    checkOutput({name, " value"}, res, expected);
    checkOutput({name, " latency"}, 32'(lat), 32'(LAT));
  endtask

  initial begin
    logic [31:0] res;
    int lat;
    bit drop;
    int readyCount;
    int unsigned cur;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset out_value", out_value, 32'h0);
    checkOutput("reset out_data_ready", 32'(out_data_ready), 32'h0);
    checkOutput("reset lut_wr_drop", 32'(lut_wr_drop), 32'h0);
    #1 rst = 1'b0;

    // Reference table: sine k/64, angle k
    for (int k = 0; k < 64; k++) writeEntry(k, kToFloat(k, -6), kToFloat(k, 0));

    runDirected("x=0.5", 32'h3F000000, 32'h42000000);
    runDirected("x=-0.5", 32'hBF000000, 32'hC2000000);
    runDirected("x=1/128", 32'h3C000000, 32'h00000000);
    runDirected("x=0x3F7F0000", 32'h3F7F0000, 32'h427C0000);
    runDirected("x=1.5", 32'h3FC00000, 32'h7FC00000);
    runDirected("x=NaN", 32'h7FC00001, 32'h7FC00000);

    // Write during search is dropped and leaves the table alone
    applyStimulus(32'h3F000000, 0, 6'd0, 32'h0, 32'h0, 1, 0, res, lat, drop);
    checkOutput("busy write drop pulse", 32'(drop), 32'h1);
    runDirected("x=0.5 after dropped write", 32'h3F000000, 32'h42000000);

    // Write on the accept edge is visible to that search
    applyStimulus(32'h3F000000, 1, 6'd40, 32'h3F000000, 32'h42200000, 0, 0, res, lat, drop);
    checkOutput("same-edge write value", res, 32'h42200000);

    // Reset mid-search aborts and clears the table
    @(negedge clk); #1;
    inp_valid = 1'b1;
    inp_value = 32'h3F000000;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("mid-search reset busy", 32'(busy), 32'h0);
    checkOutput("mid-search reset out_value", out_value, 32'h0);
    checkOutput("mid-search reset ready", 32'(out_data_ready), 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    inp_valid = 1'b1;
    inp_value = 32'h3F000000;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    checkOutput("accept on first edge after reset", 32'(busy), 32'h1);
    waitResult(0, 0, res, lat, drop);
    checkOutput("cleared table value", res, 32'h00000000);
    checkOutput("cleared table latency", 32'(lat), 32'(LAT));

    // Continuous inp_valid: one accept every LAT+1 edges
    @(negedge clk); #1;
    inp_valid = 1'b1;
    inp_value = randX();
    readyCount = 0;
    for (int n = 0; n < 32; n++) begin
      @(posedge clk); #1;
      if (out_data_ready) readyCount++;
      inp_value = randX();
    end
    inp_valid = 1'b0;
    checkOutput("continuous ready count", 32'(readyCount), 32'd4);

    // Random nondecreasing table, random angles
    cur = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0 && $urandom_range(0, 7) != 0) cur += $urandom_range(0, 32'h01FC0000);
      writeEntry(k, {1'b0, cur[30:0]}, $urandom);
    end

    // Random requests with busy-time writes and busy-time requests mixed in
    for (int t = 0; t < 80; t++) begin
      applyStimulus(randX(), 0, 6'd0, 32'h0, 32'h0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    res, lat, drop);
      checkOutput("random latency", 32'(lat), 32'(LAT));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
